// File: rtl/theta_slice_engine.sv
// Streaming theta/column-parity engine: buffers one frame of 25-bit slices,
// then emits either theta-applied slices or the raw five column parities.
module theta_slice_engine #(
  parameter int NSLICES = 64,
  parameter int ADDR_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_slice,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_slice,
  output logic        busy,
  output logic        frame_done,
  output logic        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid/out_slice never change while out_ready is low, and a
  // source whose slice is not taken must hold it until in_ready returns.

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NSLICES - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0] emit_cnt_q, emit_cnt_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              out_valid_q, out_valid_d;
  logic [24:0]       out_slice_q, out_slice_d;
  logic              prime_q, prime_d;

  logic [24:0] slice_mem [NSLICES];
  logic [4:0]  par_mem   [NSLICES];

  logic              in_fire;
  logic [4:0]        in_par;
  logic [ADDR_W-1:0] rd_z, rd_zp;
  logic [24:0]       rd_a;
  logic [4:0]        c_cur, c_prev, d_col;
  logic [24:0]       theta;
  logic [24:0]       result;

  assign in_ready    = (state_q == S_LOAD);
  assign in_fire     = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign out_slice   = out_slice_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      slice_mem[load_cnt_q] <= in_slice;
      par_mem[load_cnt_q]   <= in_par;
    end
  end

  // While a slice is on the output, look ahead to the one that replaces it.
  assign rd_z   = (out_valid_q && (emit_cnt_q != LAST)) ? emit_cnt_q + 1'b1 : emit_cnt_q;
  assign rd_zp  = (rd_z == '0) ? LAST : rd_z - 1'b1;
  assign rd_a   = slice_mem[rd_z];
  assign c_cur  = par_mem[rd_z];
  assign c_prev = par_mem[rd_zp];

  for (genvar x = 0; x < 5; x++) begin : g_col
    assign in_par[x] = in_slice[x] ^ in_slice[x+5] ^ in_slice[x+10] ^ in_slice[x+15] ^ in_slice[x+20];
    assign d_col[x]  = c_cur[(x+4)%5] ^ c_prev[(x+1)%5];
    for (genvar y = 0; y < 5; y++) begin : g_row
      assign theta[x+5*y] = rd_a[x+5*y] ^ d_col[x];
    end
  end

  assign result = mode_q ? {20'b0, c_cur} : theta;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    emit_cnt_d   = emit_cnt_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_slice_d  = out_slice_q;
    prime_d      = prime_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == '0) begin
            mode_d = mode;
            busy_d = 1'b1;
          end
          if (load_cnt_q == LAST) begin
            load_cnt_d = '0;
            state_d    = S_EMIT;
            prime_d    = 1'b1;
          end
        end
      end
      S_EMIT: begin
        // One idle cycle after entering EMIT before the first slice is registered.
        if (prime_q) begin
          prime_d = 1'b0;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_slice_d = result;
        end else if (out_ready) begin
          if (emit_cnt_q == LAST) begin
            out_valid_d  = 1'b0;
            emit_cnt_d   = '0;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_LOAD;
          end else begin
            emit_cnt_d  = emit_cnt_q + 1'b1;
            out_slice_d = result;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      load_cnt_q   <= '0;
      emit_cnt_q   <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_slice_q  <= '0;
      prime_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      emit_cnt_q   <= emit_cnt_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      out_slice_q  <= out_slice_d;
      prime_q      <= prime_d;
    end
  end

endmodule

// File: tb/tb_theta_slice_engine.sv
// Bench for theta_slice_engine: a 64-slice and an 8-slice instance, frames
// driven from a table, expected slices queued at load time and popped on output.
module tb_theta_slice_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode;
  logic        in_valid_s   [2];
  logic        in_ready_s   [2];
  logic [24:0] in_slice_s   [2];
  logic        out_valid_s  [2];
  logic        out_ready_s  [2];
  logic [24:0] out_slice_s  [2];
  logic        busy_s       [2];
  logic        frame_done_s [2];
  logic        dbg_s        [2];

  theta_slice_engine #(.NSLICES(64), .ADDR_W(6)) dut64 (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_slice(in_slice_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_slice(out_slice_s[0]),
    .busy(busy_s[0]), .frame_done(frame_done_s[0]), .dbg_state_o(dbg_s[0])
  );

  theta_slice_engine #(.NSLICES(8), .ADDR_W(3)) dut8 (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_slice(in_slice_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_slice(out_slice_s[1]),
    .busy(busy_s[1]), .frame_done(frame_done_s[1]), .dbg_state_o(dbg_s[1])
  );

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];
  logic [24:0] exp8_q[$];
  logic [24:0] frm [64];
  int   pops     [2];
  int   done_cnt [2];
  logic fd_prev  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] cpar(input logic [24:0] v);
    return v[4:0] ^ v[9:5] ^ v[14:10] ^ v[19:15] ^ v[24:20];
  endfunction

  // D[x] = C[x-1][z] ^ C[x+1][z-1], expressed as two 5-bit rotations.
  function automatic logic [24:0] ref_slice(input int n, input int z, input logic m);
    int zp;
    logic [4:0] cz, cp, d;
    zp = (z == 0) ? n - 1 : z - 1;
    cz = cpar(frm[z]);
    cp = cpar(frm[zp]);
    if (m) return {20'b0, cz};
    d = {cz[3:0], cz[4]} ^ {cp[0], cp[4:1]};
    return frm[z] ^ {5{d}};
  endfunction

  task automatic clear_frame();
    for (int z = 0; z < 64; z++) frm[z] = '0;
  endtask

  task automatic rand_frame();
    for (int z = 0; z < 64; z++) frm[z] = 25'($urandom_range(0, 32'h1ffffff));
  endtask

  // Mode is flipped after the first slice; only the first one may count.
  task automatic drive_frame(input int s, input logic m);
    int   n, t;
    logic accepted;
    n = (s == 0) ? 64 : 8;
    for (int z = 0; z < n; z++) begin
      in_valid_s[s] = 1'b1;
      in_slice_s[s] = frm[z];
      mode = (z == 0) ? m : ~m;
      accepted = 1'b0;
      t = 0;
      while (!accepted && t < 400) begin
        @(negedge clk);
        accepted = in_ready_s[s];
        @(posedge clk); #1;
        t++;
      end
      check_eq("in_accept", accepted, 1);
      if (!accepted) begin
        in_valid_s[s] = 1'b0;
        return;
      end
      if (z == 0) check_eq("busy_load", busy_s[s], 1);
    end
    in_valid_s[s] = 1'b0;
    for (int z = 0; z < n; z++) begin
      if (s == 0) exp_q.push_back(ref_slice(n, z, m));
      else exp8_q.push_back(ref_slice(n, z, m));
    end
  endtask

  task automatic wait_done(input int s, input int target);
    int t;
    t = 0;
    while (done_cnt[s] < target && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("done_wait", done_cnt[s], target);
  endtask

  task automatic check_reset_vals(input int s);
    check_eq("rst_in_ready",   in_ready_s[s],   1);
    check_eq("rst_out_valid",  out_valid_s[s],  0);
    check_eq("rst_out_slice",  out_slice_s[s],  0);
    check_eq("rst_busy",       busy_s[s],       0);
    check_eq("rst_frame_done", frame_done_s[s], 0);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        pops[s]    = 0;
        fd_prev[s] = 1'b0;
        if (s == 0) exp_q.delete();
        else exp8_q.delete();
      end else begin
        if (fd_prev[s]) check_eq("fd_width", frame_done_s[s], 0);
        fd_prev[s] = frame_done_s[s];
        if (frame_done_s[s]) begin
          done_cnt[s]++;
          check_eq("fd_count", pops[s], (s == 0) ? 64 : 8);
          check_eq("fd_busy", busy_s[s], 0);
          pops[s] = 0;
        end
        if (out_valid_s[s]) begin
          check_eq("emit_busy", busy_s[s], 1);
          check_eq("emit_in_ready", in_ready_s[s], 0);
        end
        if (out_valid_s[s] && out_ready_s[s]) begin
          pops[s]++;
          if (s == 0) begin
            check_eq("q64_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
              check_eq($sformatf("out64[%0d]", pops[s] - 1), out_slice_s[0], exp_q.pop_front());
          end else begin
            check_eq("q8_avail", exp8_q.size() != 0, 1);
            if (exp8_q.size() != 0)
              check_eq($sformatf("out8[%0d]", pops[s] - 1), out_slice_s[1], exp8_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] held;
    int t, dsave;
    rst = 1'b1;
    mode = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid_s[s]  = 1'b0;
      in_slice_s[s]  = '0;
      out_ready_s[s] = 1'b1;
      pops[s]        = 0;
      done_cnt[s]    = 0;
      fd_prev[s]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);

    // All-zero frame, with first-output latency check.
    clear_frame();
    drive_frame(0, 1'b0);
    @(negedge clk); check_eq("lat_c1", out_valid_s[0], 0);
    @(negedge clk); check_eq("lat_c2", out_valid_s[0], 0);
    @(negedge clk); check_eq("lat_c3", out_valid_s[0], 1);
    wait_done(0, 1);

    // Single bit in slice 0, then in slice 63 (wrap of zp).
    clear_frame(); frm[0] = 25'h0000001;
    drive_frame(0, 1'b0);
    wait_done(0, 2);
    clear_frame(); frm[63] = 25'h0000001;
    drive_frame(0, 1'b0);
    wait_done(0, 3);

    // Parity-only mode.
    clear_frame(); frm[0] = 25'h0000021; frm[5] = 25'h0000002;
    drive_frame(0, 1'b1);
    wait_done(0, 4);

    // Output stall at slice 10, next frame held at the input during EMIT.
    rand_frame();
    drive_frame(0, 1'b0);
    t = 0;
    while (pops[0] != 10 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("stall_reach", pops[0], 10);
    out_ready_s[0] = 1'b0;
    held = out_slice_s[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", out_valid_s[0], 1);
      check_eq("stall_slice", out_slice_s[0], held);
      @(posedge clk);
    end
    #1;
    out_ready_s[0] = 1'b1;
    rand_frame();
    drive_frame(0, 1'b1);
    wait_done(0, 6);

    // Reset in the middle of EMIT with out_valid high.
    rand_frame();
    drive_frame(0, 1'b0);
    t = 0;
    while (pops[0] != 20 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("abort_reach", pops[0], 20);
    check_eq("abort_valid", out_valid_s[0], 1);
    out_ready_s[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready_s[0] = 1'b1;
    check_reset_vals(0);
    dsave = done_cnt[0];
    repeat (10) @(posedge clk);
    #1;
    check_eq("no_stale_fd", done_cnt[0], dsave);
    check_eq("abort_idle", out_valid_s[0], 0);

    // 8-slice build: wrap frame, then random frames under random backpressure.
    clear_frame(); frm[7] = 25'h0000001;
    drive_frame(1, 1'b0);
    wait_done(1, 1);
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      drive_frame(1, f[0]);
      t = 0;
      while (done_cnt[1] < f + 2 && t < 500) begin
        @(posedge clk); #1;
        out_ready_s[1] = ($urandom_range(0, 3) != 0);
        t++;
      end
      out_ready_s[1] = 1'b1;
      check_eq("rand8_done", done_cnt[1], f + 2);
    end

    // 64-slice instance recovers after the abort.
    rand_frame();
    drive_frame(0, 1'b0);
    wait_done(0, dsave + 1);

    check_eq("q64_drained", exp_q.size(), 0);
    check_eq("q8_drained", exp8_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
